pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the decode stage and sequences the IF/ID and ID/EX pipeline registers and the PC. It inserts load-use bubbles, flushes on taken branches and jumps, and freezes the pipeline while data memory is busy, with a timeout. It also exports a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MAX_WAIT, default 64: maximum consecutive dmem_busy cycles before the error state; legal range 2..255.
- CNT_W, default 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, beq).
- ex_memread  in  1  instruction in EX is a load (MEM[1] of ID/EX).
- ex_rt  in  5  destination rt of the instruction in EX (rt_addr_ex).
- id_redirect  in  1  taken branch or jump resolved in ID.
- dmem_busy  in  1  data memory cannot complete the current MEM access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_bubble  out  1  ID/EX register loads all-zero controls.
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB registers hold their values.
- err  out  1  memory timeout; sticky until reset.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0, saturating.

## Operation
Hazard term: lu = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).

Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0.

FSM states: RUN, STALL, WAIT, ERR.

- **RUN**, evaluated in priority order:
  - dmem_busy: freeze (pc_write=0, ifid_write=0, pipe_hold=1). Go to WAIT with wait_cnt←1.
  - else lu: pc_write=0, ifid_write=0, idex_bubble=1. Go to STALL.
  - else id_redirect: ifid_flush=1, idex_bubble=1. Stay in RUN.
  - else normal advance.
- **STALL**: lasts exactly one cycle. Same rules as RUN except the lu term is ignored, so a bubble is never doubled. Exits per those rules to WAIT or RUN.
- **WAIT**:
  - dmem_busy=1 and wait_cnt < MAX_WAIT: freeze, and wait_cnt increments.
  - dmem_busy=1 and wait_cnt == MAX_WAIT: freeze, err←1, go to ERR.
  - dmem_busy=0: the access completes this cycle. Outputs and next state follow the RUN rules, including lu and id_redirect.
- **ERR**: permanent freeze with err=1. Only rst leaves ERR.

Counting and reset:
- stall_cnt increments on every clock edge where pc_write=0. It holds at 2^CNT_W−1.
- While rst is high, all outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, err=0, stall_cnt=0.
- While rst is high, state=RUN and wait_cnt=0.

## Timing
- All control outputs are combinational from state and inputs. They are valid in the same cycle the hazard is presented, with zero latency.
- state, wait_cnt, err and stall_cnt are registered. Their asynchronous reset values are RUN, 0, 0, 0.
- Load-use costs exactly 1 bubble cycle. Redirect costs 1 flushed fetch plus the ID/EX bubble. A memory wait of N busy cycles costs N frozen cycles.
- Simultaneous events: dmem_busy beats lu, and lu beats id_redirect. A redirect coinciding with lu is re-presented after the stall, because IF/ID holds the branch.
- Reset mid-WAIT or in ERR: the next cycle after deassertion starts in RUN with counters cleared.
- wait_cnt is 8 bits and never wraps, because MAX_WAIT ≤ 255.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum with encodings RUN=2'd0, STALL=2'd1, WAIT=2'd2, ERR=2'd3;
  - the REG_ZERO=5'd0 constant.
- One natural sub-module, hazard_cmp: purely combinational, it computes lu from the ID/EX register-address inputs.
- The FSM, the counters and output decode stay in pipe_hazard_ctrl.

## Test plan
- **Load-use**: ex_memread=1, ex_rt=8, id_rs=8 → one cycle of pc_write=0, idex_bubble=1, state STALL. The next cycle has pc_write=1 and stall_cnt=1.
- **Register $0 and the id_uses_rt gate**:
  - ex_memread=1, ex_rt=0, id_rs=0 → no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
- **Redirect**: id_redirect=1 with no hazard → ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN.
- **Memory wait**:
  - dmem_busy high for 3 cycles → pipe_hold=1 and pc_write=0 for 3 cycles, stall_cnt=3.
  - On the 4th cycle dmem_busy=0 with lu=1 → a bubble is inserted that same cycle.
- **Timeout**: MAX_WAIT=4 with dmem_busy held high → err=1 after the 5th busy cycle, permanent freeze. An rst pulse returns to RUN with err=0 and stall_cnt=0.
- **Priority and saturation**:
  - dmem_busy=1, lu=1 and id_redirect=1 together → freeze only, state WAIT.
  - With CNT_W=4 and 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StWait  = 2'd2,
        StErr   = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detect: a load in EX whose destination feeds a source of the ID instruction.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt & (ex_rt == id_rt);
        // $0 is never a real dependency
        lu       = ex_memread & (ex_rt != REG_ZERO) & (rs_match | rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, redirect flushes, memory-wait freeze with timeout,
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             id_redirect,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lu;
    logic pc_w, ifid_w, flush, bubble, hold;
    logic apply_run, lu_en;

    hazard_cmp u_hazard_cmp (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .lu         (lu)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        flush      = 1'b0;
        bubble     = 1'b0;
        hold       = 1'b0;
        apply_run  = 1'b0;
        lu_en      = 1'b0;

        unique case (state_q)
            StRun: begin
                apply_run = 1'b1;
                lu_en     = 1'b1;
            end
            // lu ignored so a bubble is never doubled
            StStall: apply_run = 1'b1;
            StWait: begin
                if (dmem_busy) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    hold   = 1'b1;
                    if (wait_cnt_q == MAX_WAIT_C) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    apply_run = 1'b1;
                    lu_en     = 1'b1;
                end
            end
            StErr: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                hold   = 1'b1;
            end
            default: state_d = StRun;
        endcase

        if (apply_run) begin
            if (dmem_busy) begin
                pc_w       = 1'b0;
                ifid_w     = 1'b0;
                hold       = 1'b1;
                state_d    = StWait;
                wait_cnt_d = 8'd1;
            end else if (lu && lu_en) begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                bubble  = 1'b1;
                state_d = StStall;
            end else if (id_redirect) begin
                flush   = 1'b1;
                bubble  = 1'b1;
                state_d = StRun;
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            if (!pc_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end else begin
            pc_write    = pc_w;
            ifid_write  = ifid_w;
            ifid_flush  = flush;
            idex_bubble = bubble;
            pipe_hold   = hold;
        end
        err       = err_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MAX_WAIT=4 and CNT_W=4.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       id_redirect;
    logic       dmem_busy;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       pipe_hold;
    logic       err;
    logic [3:0] stall_cnt;

    int checks;
    int failures;

    pipe_hazard_ctrl #(
        .MAX_WAIT (4),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .id_redirect (id_redirect),
        .dmem_busy   (dmem_busy),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .pipe_hold   (pipe_hold),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        ex_memread  = 1'b0;
        ex_rt       = 5'd0;
        id_redirect = 1'b0;
        dmem_busy   = 1'b0;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1;
        ex_rt      = 5'd8;
        id_rs      = 5'd8;
    endtask

    // advance one clock, land just after the edge, then settle before checks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pcw"},   16'(pc_write),    16'd0);
        chk({tag, "_ifw"},   16'(ifid_write),  16'd0);
        chk({tag, "_flush"}, 16'(ifid_flush),  16'd1);
        chk({tag, "_bub"},   16'(idex_bubble), 16'd1);
        chk({tag, "_hold"},  16'(pipe_hold),   16'd0);
        chk({tag, "_err"},   16'(err),         16'd0);
        chk({tag, "_cnt"},   16'(stall_cnt),   16'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        #2;
        chk_reset_outs("rst0");
        tick();
        rst = 1'b0;
        #2;
        chk("idle_pcw",   16'(pc_write),      16'd1);
        chk("idle_state", 16'(dut.state_q),   16'(StRun));

        // load-use: one bubble
        set_lu();
        #2;
        chk("lu_pcw",   16'(pc_write),    16'd0);
        chk("lu_ifw",   16'(ifid_write),  16'd0);
        chk("lu_bub",   16'(idex_bubble), 16'd1);
        chk("lu_hold",  16'(pipe_hold),   16'd0);
        tick();
        chk("lu_state", 16'(dut.state_q), 16'(StStall));
        chk("lu_cnt",   16'(stall_cnt),   16'd1);
        #2;
        chk("stall_pcw", 16'(pc_write),    16'd1);
        chk("stall_bub", 16'(idex_bubble), 16'd0);
        tick();
        chk("stall_exit", 16'(dut.state_q), 16'(StRun));
        chk("stall_cnt1", 16'(stall_cnt),   16'd1);

        // $0 destination and id_uses_rt gate
        idle();
        ex_memread = 1'b1;
        #2;
        chk("r0_pcw", 16'(pc_write), 16'd1);
        ex_rt = 5'd9;
        id_rt = 5'd9;
        #2;
        chk("rt_gate_pcw", 16'(pc_write), 16'd1);
        id_uses_rt = 1'b1;
        #2;
        chk("rt_use_pcw", 16'(pc_write), 16'd0);
        tick();
        idle();
        tick();
        chk("rt_use_cnt", 16'(stall_cnt), 16'd2);

        // redirect without hazard
        id_redirect = 1'b1;
        #2;
        chk("rd_flush", 16'(ifid_flush),  16'd1);
        chk("rd_bub",   16'(idex_bubble), 16'd1);
        chk("rd_pcw",   16'(pc_write),    16'd1);
        chk("rd_ifw",   16'(ifid_write),  16'd1);
        tick();
        chk("rd_state", 16'(dut.state_q), 16'(StRun));
        chk("rd_cnt",   16'(stall_cnt),   16'd2);

        // memory wait of 3 cycles, then lu on the completing cycle
        idle();
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_hold", 16'(pipe_hold), 16'd1);
            chk("mw_pcw",  16'(pc_write),  16'd0);
            tick();
        end
        chk("mw_state", 16'(dut.state_q),    16'(StWait));
        chk("mw_wcnt",  16'(dut.wait_cnt_q), 16'd3);
        chk("mw_cnt",   16'(stall_cnt),      16'd5);
        dmem_busy = 1'b0;
        set_lu();
        #2;
        chk("mw_lu_pcw",  16'(pc_write),    16'd0);
        chk("mw_lu_bub",  16'(idex_bubble), 16'd1);
        chk("mw_lu_hold", 16'(pipe_hold),   16'd0);
        tick();
        chk("mw_lu_state", 16'(dut.state_q), 16'(StStall));
        chk("mw_lu_cnt",   16'(stall_cnt),   16'd6);
        idle();
        tick();

        // all three events together: freeze wins, then timeout
        dmem_busy   = 1'b1;
        id_redirect = 1'b1;
        set_lu();
        #2;
        chk("pri_pcw",   16'(pc_write),    16'd0);
        chk("pri_hold",  16'(pipe_hold),   16'd1);
        chk("pri_flush", 16'(ifid_flush),  16'd0);
        chk("pri_bub",   16'(idex_bubble), 16'd0);
        tick();
        chk("pri_state", 16'(dut.state_q),    16'(StWait));
        chk("pri_wcnt",  16'(dut.wait_cnt_q), 16'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("to_wcnt4", 16'(dut.wait_cnt_q), 16'd4);
        chk("to_err_b", 16'(err),            16'd0);
        chk("to_cnt4",  16'(stall_cnt),      16'd10);
        tick();
        chk("to_err",   16'(err),           16'd1);
        chk("to_state", 16'(dut.state_q),   16'(StErr));
        chk("to_cnt5",  16'(stall_cnt),     16'd11);
        idle();
        #2;
        chk("err_pcw",  16'(pc_write),  16'd0);
        chk("err_hold", 16'(pipe_hold), 16'd1);
        tick();
        chk("err_stick", 16'(err),       16'd1);
        chk("err_cnt",   16'(stall_cnt), 16'd12);

        // reset out of ERR
        rst = 1'b1;
        #2;
        chk_reset_outs("rst1");
        tick();
        rst = 1'b0;
        #2;
        chk("rst1_state", 16'(dut.state_q), 16'(StRun));
        chk("rst1_pcw",   16'(pc_write),    16'd1);
        tick();
        chk("rst1_cnt", 16'(stall_cnt), 16'd0);

        // saturation: stay frozen for 20 cycles
        dmem_busy = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 16'(stall_cnt), 16'd14);
        tick();
        chk("sat_15", 16'(stall_cnt), 16'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_20", 16'(stall_cnt), 16'd15);
        chk("sat_err", 16'(err),      16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
